// File: rtl/button_pkg.sv
// Shared types and 100 MHz timing defaults for the push-button conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } btn_state_t;

  localparam int unsigned BTN_SYNC_STAGES   = 2;
  localparam int unsigned BTN_DEBOUNCE_10MS = 1_000_000;
  localparam int unsigned BTN_LONG_2S       = 200_000_000;

endpackage

// File: rtl/btn_sync.sv
// Multi-flop synchroniser bringing the asynchronous button pin into clk.
module btn_sync
  import button_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = BTN_SYNC_STAGES
) (
  input  logic clk,
  input  logic ck_rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge ck_rst) begin
    if (!ck_rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Push-button synchroniser, debouncer and press/ack handshake for the reaction timer.
// Optional long-press detection: define BUTTON_CONDITIONER_LONGPRESS_EN.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = BTN_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_10MS,
  parameter int unsigned LONG_CYCLES     = BTN_LONG_2S
) (
  input  logic clk,
  input  logic ck_rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_valid,
  input  logic press_ack,
  output logic release_pulse,
  output logic overrun,
  output logic long_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  btn_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             s;
  logic             press_evt;
  logic             release_evt;

  btn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .ck_rst (ck_rst),
    .d      (btn_raw),
    .q      (s)
  );

  always_ff @(posedge clk or negedge ck_rst) begin
    if (!ck_rst) begin
      state <= RELEASED;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    press_evt   = 1'b0;
    release_evt = 1'b0;
    case (state)
      RELEASED: begin
        if (s) begin
          state_n = PRESS_CHK;
          cnt_n   = CNT_W'(1);
        end
      end
      PRESS_CHK: begin
        if (!s) begin
          state_n = RELEASED;
          cnt_n   = '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
          state_n   = PRESSED;
          cnt_n     = '0;
          press_evt = 1'b1;
        end else if (cnt != '1) begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_n = RELEASE_CHK;
          cnt_n   = CNT_W'(1);
        end
      end
      RELEASE_CHK: begin
        if (s) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
          state_n     = RELEASED;
          cnt_n       = '0;
          release_evt = 1'b1;
        end else if (cnt != '1) begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = RELEASED;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land on the same edge as the transition.
  always_ff @(posedge clk or negedge ck_rst) begin
    if (!ck_rst) begin
      btn_level     <= 1'b0;
      release_pulse <= 1'b0;
      press_valid   <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      btn_level     <= (state_n == PRESSED) || (state_n == RELEASE_CHK);
      release_pulse <= release_evt;
      if (press_evt) begin
        press_valid <= 1'b1;
        if (press_valid && !press_ack) begin
          overrun <= 1'b1;
        end
      end else if (press_ack) begin
        press_valid <= 1'b0;
      end
    end
  end

`ifdef BUTTON_CONDITIONER_LONGPRESS_EN
  localparam int unsigned LC_W = $clog2(LONG_CYCLES + 1);

  logic [LC_W-1:0] long_cnt;
  logic            held;

  assign held = (state == PRESSED) || (state == RELEASE_CHK);

  // Saturating at LONG_CYCLES is what limits the pulse to once per press.
  always_ff @(posedge clk or negedge ck_rst) begin
    if (!ck_rst) begin
      long_cnt   <= '0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= 1'b0;
      if (press_evt) begin
        long_cnt <= '0;
      end else if (held && (long_cnt != LC_W'(LONG_CYCLES))) begin
        long_cnt   <= long_cnt + LC_W'(1);
        long_pulse <= (long_cnt == LC_W'(LONG_CYCLES - 1));
      end
    end
  end
`else
  // Constant zero; the comparison only keeps LONG_CYCLES referenced in this build.
  assign long_pulse = (LONG_CYCLES == 0) && 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed bench for button_conditioner against a run-length debounce model.
module tb_button_conditioner;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 4;
  localparam int unsigned LONG = 20;
`ifdef BUTTON_CONDITIONER_LONGPRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic ck_rst;
  logic btn_raw;
  logic press_ack;
  logic btn_level, press_valid, release_pulse, overrun, long_pulse;

  int total = 0;
  int bad   = 0;

  // Reference model: the level flips after DEB+1 consecutive synchronised samples disagreeing with it.
  bit m_hist[$];
  bit m_level, m_pv, m_ov, m_rp, m_lp;
  int m_run, m_lc;

  button_conditioner #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG)
  ) dut (
    .clk           (clk),
    .ck_rst        (ck_rst),
    .btn_raw       (btn_raw),
    .btn_level     (btn_level),
    .press_valid   (press_valid),
    .press_ack     (press_ack),
    .release_pulse (release_pulse),
    .overrun       (overrun),
    .long_pulse    (long_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < int'(SYNC); i++) m_hist.push_back(1'b0);
    m_level = 0; m_pv = 0; m_ov = 0; m_rp = 0; m_lp = 0;
    m_run = 0; m_lc = 0;
  endtask

  task automatic model_step(input bit raw, input bit ack);
    bit x, prev, rise, fall;
    x = m_hist.pop_front();
    m_hist.push_back(raw);
    prev = m_level;
    rise = 0; fall = 0;
    m_run = (x != m_level) ? m_run + 1 : 0;
    if (m_run == int'(DEB) + 1) begin
      m_level = ~m_level;
      m_run   = 0;
      rise    = m_level;
      fall    = ~m_level;
    end
    m_rp = fall;
    m_lp = 0;
    if (rise) m_lc = 0;
    else if (prev && m_lc < int'(LONG)) begin
      m_lc++;
      m_lp = (m_lc == int'(LONG)) && LP_EN;
    end
    if (rise) begin
      if (m_pv && !ack) m_ov = 1;
      m_pv = 1;
    end else if (ack) begin
      m_pv = 0;
    end
  endtask

  task automatic check_all(input string where);
    chk({where, ".btn_level"},     btn_level,     m_level);
    chk({where, ".press_valid"},   press_valid,   m_pv);
    chk({where, ".overrun"},       overrun,       m_ov);
    chk({where, ".release_pulse"}, release_pulse, m_rp);
    chk({where, ".long_pulse"},    long_pulse,    m_lp);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!ck_rst) model_reset();
    else model_step(btn_raw, press_ack);
    #1;
    check_all("model");
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_level_change(input logic to_v, input string tag);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk({tag, ".early"}, btn_level, ~to_v);
    end
    tick();
    chk({tag, ".edge7"}, btn_level, to_v);
  endtask

  initial begin
    ck_rst = 1'b0; btn_raw = 1'b0; press_ack = 1'b0;
    model_reset();
    ticks(2);
    chk("reset.btn_level", btn_level, 1'b0);
    chk("reset.press_valid", press_valid, 1'b0);
    chk("reset.overrun", overrun, 1'b0);
    ck_rst = 1'b1;
    ticks(4);

    // Clean press: rise on the 7th edge after the raw change
    btn_raw = 1'b1;
    expect_level_change(1'b1, "clean_press");
    chk("clean_press.pv", press_valid, 1'b1);
    chk("clean_press.ov", overrun, 1'b0);

    // Ack three cycles after press_valid
    ticks(2);
    press_ack = 1'b1;
    tick();
    press_ack = 1'b0;
    chk("ack.pv_clear", press_valid, 1'b0);

    // Long press pulse 20 edges after the rise (edge 27 of this press)
    ticks(16);
    chk("long.before", long_pulse, 1'b0);
    tick();
    chk("long.at20", long_pulse, LP_EN);
    ticks(10);

    // Release with one-cycle release_pulse
    btn_raw = 1'b0;
    expect_level_change(1'b0, "release");
    chk("release.pulse", release_pulse, 1'b1);
    tick();
    chk("release.pulse_end", release_pulse, 1'b0);
    ticks(3);

    // Bounce then settle high
    for (int i = 0; i < 6; i++) begin
      btn_raw = (i % 2 == 0);
      ticks(2);
      chk("bounce.no_change", btn_level, 1'b0);
    end
    btn_raw = 1'b1;
    expect_level_change(1'b1, "bounce_settle");
    chk("bounce_settle.ov", overrun, 1'b0);
    ticks(2);
    btn_raw = 1'b0;
    ticks(10);

    // New press coinciding with ack: press_valid stays, no overrun
    btn_raw = 1'b1;
    ticks(6);
    press_ack = 1'b1;
    tick();
    press_ack = 1'b0;
    chk("coincide.pv", press_valid, 1'b1);
    chk("coincide.ov", overrun, 1'b0);
    ticks(2);
    btn_raw = 1'b0;
    ticks(10);

    // Second press without ack: sticky overrun
    btn_raw = 1'b1;
    ticks(7);
    chk("overrun.set", overrun, 1'b1);
    btn_raw = 1'b0;
    ticks(12);
    chk("overrun.sticky", overrun, 1'b1);

    // Reset mid-debounce with raw held high
    btn_raw = 1'b1;
    ticks(4);
    ck_rst = 1'b0;
    #1;
    model_reset();
    chk("rst_mid.btn_level", btn_level, 1'b0);
    chk("rst_mid.press_valid", press_valid, 1'b0);
    chk("rst_mid.overrun", overrun, 1'b0);
    chk("rst_mid.release_pulse", release_pulse, 1'b0);
    chk("rst_mid.long_pulse", long_pulse, 1'b0);
    ticks(2);
    ck_rst = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("rst_rel.pv_early", press_valid, 1'b0);
    end
    tick();
    chk("rst_rel.pv_edge7", press_valid, 1'b1);
    ticks(3);

    // Randomised segments with random acks
    for (int seg = 0; seg < 60; seg++) begin
      int len;
      btn_raw = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 12));
      if (seg % 15 == 14) len = 30;
      for (int k = 0; k < len; k++) begin
        press_ack = ($urandom_range(0, 3) == 0);
        tick();
      end
    end
    press_ack = 1'b0;
    ticks(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Input-side conditioner for the reaction timer's player push-button. It synchronises the raw button pin into `clk`, debounces it with a counter-qualified state machine, and presents a clean level plus a press event. The press event is held until the reaction-timer FSM acknowledges it, so the timer never misses or double-counts a press. The block sits between the board button pin and the reaction-timer control FSM; it is the receive-direction counterpart of the timer's LED and display outputs.

## Interface
- `SYNC_STAGES`, default 2: flip-flops in the input synchroniser (≥2).
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable samples needed to accept a level change (10 ms at 100 MHz; ≥1).
- `LONG_CYCLES`, default 200_000_000: held-pressed cycles that qualify as a long press (used only with the macro).
- `clk` in 1: system clock; single clock domain.
- `ck_rst` in 1: asynchronous, active-low reset.
- `btn_raw` in 1: raw, asynchronous, bouncing button pin (1 = pressed).
- `btn_level` out 1: debounced button level.
- `press_valid` out 1: a debounced press is pending.
- `press_ack` in 1: consumer acknowledges the pending press.
- `release_pulse` out 1: one-cycle pulse on debounced release.
- `overrun` out 1: sticky; a press arrived while `press_valid` was still high.
- `long_pulse` out 1: one-cycle pulse on long press (see Configuration).

## Operation
- **Synchroniser:** `btn_raw` passes through `SYNC_STAGES` flops, producing `s`. Only `s` is used downstream.
- **FSM states:**
  - RELEASED, `btn_level` = 0. If `s` = 1, go to PRESS_CHK and set cnt = 1.
  - PRESS_CHK:
    - If `s` = 0, go to RELEASED and clear cnt.
    - Else, if cnt = `DEBOUNCE_CYCLES`, go to PRESSED.
    - Else, increment cnt.
  - PRESSED, `btn_level` = 1. If `s` = 0, go to RELEASE_CHK and set cnt = 1.
  - RELEASE_CHK:
    - If `s` = 1, go to PRESSED and clear cnt. The long-press counter is not cleared.
    - Else, if cnt = `DEBOUNCE_CYCLES`, go to RELEASED.
    - Else, increment cnt.
- **cnt width:** `$clog2(DEBOUNCE_CYCLES+1)`. cnt saturates and never wraps.
- **PRESS_CHK → PRESSED:** sets `press_valid`. If `press_valid` was already 1 and `press_ack` is not asserted that cycle, also sets `overrun`.
- **`press_valid` handshake:**
  - Cleared on the cycle after `press_ack` = 1 while `press_valid` = 1.
  - If a new press and the ack land in the same cycle, `press_valid` stays 1 and `overrun` stays 0.
  - `press_ack` while `press_valid` = 0 is ignored.
- **`overrun`:** cleared only by reset.
- **`release_pulse`:** asserted in the cycle the FSM enters RELEASED from RELEASE_CHK.
- **Reset (any time, including mid-debounce):**
  - FSM goes to RELEASED and cnt to 0.
  - Synchroniser flops, `btn_level`, `press_valid`, `release_pulse`, `overrun` and `long_pulse` all go to 0.
  - A button held through reset release is reported as a fresh press after full debounce.

## Timing
- **Raw rising edge to `btn_level` = 1 and `press_valid` = 1:** exactly `SYNC_STAGES + DEBOUNCE_CYCLES + 1` clock edges, given a clean edge.
- **Raw falling edge to `btn_level` = 0:** same latency. `release_pulse` is high in that same cycle.
- **Glitches:** any glitch shorter than `DEBOUNCE_CYCLES` samples on `s` produces no output change.
- **Outputs:** all registered; no combinational path from inputs to outputs.
- **`press_valid` fall:** one cycle after the acknowledging edge.

## Configuration
- **Macro:** `BUTTON_CONDITIONER_LONGPRESS_EN`.
- **Defined:**
  - A long counter of width `$clog2(LONG_CYCLES+1)` clears on entry to PRESSED from PRESS_CHK.
  - It increments and saturates while in PRESSED or RELEASE_CHK.
  - When it reaches `LONG_CYCLES`, `long_pulse` is high for exactly one cycle. This happens at most once per press.
- **Not defined:** `long_pulse` is tied to 0 and no long-counter logic exists.

## Structure
- **Package `button_pkg`:** FSM state enum (RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK) and the default timing constants at 100 MHz (`BTN_DEBOUNCE_10MS`, `BTN_LONG_2S`).
- **Sub-module `btn_sync`:** parameterised `SYNC_STAGES` flop chain with async active-low reset. Instantiated once.

## Test plan
Bench parameters: `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=20.

- **Clean press:** `btn_raw` 0→1 at edge 0 and held → `btn_level` and `press_valid` rise at edge 7; `overrun` stays 0.
- **Bounce:** `btn_raw` toggles every 2 cycles for 12 cycles, then holds 1 → no `btn_level` change during the bounce; the rise comes 7 edges after the final stable 1.
- **Handshake:** `press_ack` pulse 3 cycles after `press_valid` → `press_valid` 0 on the next edge. A second clean press without ack → `overrun` = 1 and stays 1. A new press coinciding with ack → `press_valid` stays 1, no `overrun`.
- **Release:** after press, `btn_raw` 1→0 → `btn_level` falls and `release_pulse` is high for exactly one cycle, 7 edges later.
- **Reset mid-debounce:** assert `ck_rst`=0 during PRESS_CHK with raw held 1 → all outputs 0 immediately. On release, `press_valid` rises 7 edges after deassertion.
- **Long press (macro defined):** hold pressed → `long_pulse` high for one cycle 20 cycles after `btn_level` rises, and no second pulse. Without the macro, `long_pulse` stays 0.
